// File: rtl/psx_irq_pkg.sv
// Shared definitions for the PSX interrupt controller: source count, register
// addresses, source bit positions and the bus handshake state type.
package psx_irq_pkg;

  localparam int          IRQ_NUM_SRC = 11;
  localparam logic [31:0] I_STAT_ADDR = 32'h1F80_1070;
  localparam logic [31:0] I_MASK_ADDR = 32'h1F80_1074;

  // Bit positions of each hardware source in I_STAT / I_MASK
  localparam int IRQ_VBLANK   = 0;
  localparam int IRQ_GPU      = 1;
  localparam int IRQ_CDROM    = 2;
  localparam int IRQ_DMA      = 3;
  localparam int IRQ_TMR0     = 4;
  localparam int IRQ_TMR1     = 5;
  localparam int IRQ_TMR2     = 6;
  localparam int IRQ_PAD      = 7;
  localparam int IRQ_SIO      = 8;
  localparam int IRQ_SPU      = 9;
  localparam int IRQ_LIGHTPEN = 10;

  // IDLE: waiting for a request; RESP: ack cycle; HOLD: wait for request release
  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_RESP = 2'd1,
    BUS_HOLD = 2'd2
  } bus_state_t;

  // Expand 4 byte enables into a 32-bit bit mask
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for the interrupt source levels.
// Build option IRQ_SYNC_EN: inserts a two-flop synchronizer on every bit ahead
// of the edge detect (adds two cycles of interrupt latency).
// During reset every stage loads the live source value, so a source already
// high when reset releases does not produce a rise.
module irq_edge_detect #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] src,
  output logic [W-1:0] rise
);

  logic [W-1:0] src_s;
  logic [W-1:0] src_q;

`ifdef IRQ_SYNC_EN
  logic [W-1:0] sync1;
  logic [W-1:0] sync2;

  // Two-flop synchronizer; both stages preload the raw level in reset
  always_ff @(posedge clk) begin
    sync1 <= src;
    if (rst) sync2 <= src;
    else     sync2 <= sync1;
  end

  assign src_s = sync2;
`else
  assign src_s = src;
`endif

  // Previous-sample register used for edge detection
  always_ff @(posedge clk) begin
    if (rst) src_q <= src;
    else     src_q <= src_s;
  end

  assign rise = src_s & ~src_q;

endmodule

// File: rtl/irq_controller.sv
// PSX interrupt controller: latches source rising edges into I_STAT, gates
// them with I_MASK and drives the CPU interrupt line.
// Build option IRQ_SYNC_EN (inside irq_edge_detect) synchronizes irq_src.
// Bus handshake: a request (wen or ren held high) hitting I_STAT or I_MASK is
// accepted only from IDLE and executes exactly once on that edge; ack is
// high for the following single cycle; the FSM then waits in HOLD until the
// requester drops both wen and ren before accepting a new request.
module irq_controller
  import psx_irq_pkg::*;
#(
  parameter int          NUM_SRC   = IRQ_NUM_SRC,
  parameter logic [31:0] BASE_ADDR = I_STAT_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr,
  input  logic [31:0]        data_i,
  input  logic               wen,
  input  logic               ren,
  input  logic [3:0]         be,
  output logic               ack,
  output logic [31:0]        data_o,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               cpu_irq,
  output bus_state_t         dbg_state
);

  localparam logic [31:0] MASK_ADDR = BASE_ADDR + 32'd4;

  bus_state_t         state;
  bus_state_t         state_next;
  logic [NUM_SRC-1:0] stat;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] stat_next;
  logic [NUM_SRC-1:0] mask_next;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] wmask;
  logic [NUM_SRC-1:0] wdat;
  logic [31:0]        be_bits;
  logic               hit_stat;
  logic               hit_mask;
  logic               access;
  logic               unused_bits;

  assign hit_stat = (addr[31:2] == BASE_ADDR[31:2]);
  assign hit_mask = (addr[31:2] == MASK_ADDR[31:2]);
  assign access   = (state == BUS_IDLE) && (wen || ren) && (hit_stat || hit_mask);
  assign be_bits  = byte_mask(be);
  assign wmask    = be_bits[NUM_SRC-1:0];
  assign wdat     = data_i[NUM_SRC-1:0];

  // Byte offset and bits above the register width carry no meaning here
  assign unused_bits = ^{addr[1:0], data_i[31:NUM_SRC], be_bits[31:NUM_SRC]};

  irq_edge_detect #(.W(NUM_SRC)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .src  (irq_src),
    .rise (rise)
  );

  // Bus FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= BUS_IDLE;
    else     state <= state_next;
  end

  // Bus FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      BUS_IDLE: if (access)      state_next = BUS_RESP;
      BUS_RESP:                  state_next = BUS_HOLD;
      BUS_HOLD: if (!wen && !ren) state_next = BUS_IDLE;
      default:                   state_next = BUS_IDLE;
    endcase
  end

  // Bus FSM outputs
  always_comb begin
    ack       = (state == BUS_RESP);
    dbg_state = state;
  end

  // Register update: write ack-clears or mask load, then new edges (set wins)
  always_comb begin
    stat_next = stat;
    mask_next = mask;
    if (access && wen && hit_stat) stat_next = stat & (wdat | ~wmask);
    if (access && wen && hit_mask) mask_next = (mask & ~wmask) | (wdat & wmask);
    stat_next = stat_next | rise;
  end

  // Register file and read-data capture (reads see the pre-update value)
  always_ff @(posedge clk) begin
    if (rst) begin
      stat   <= '0;
      mask   <= '0;
      data_o <= '0;
    end else begin
      stat <= stat_next;
      mask <= mask_next;
      if (access && ren) begin
        if (wen)           data_o <= '0;
        else if (hit_stat) data_o <= {{(32-NUM_SRC){1'b0}}, stat};
        else               data_o <= {{(32-NUM_SRC){1'b0}}, mask};
      end
    end
  end

  assign cpu_irq = |(stat & mask);

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized
// source activity and bus traffic, checked against a register-level model.
`timescale 1ns/1ps
module tb_irq_controller;
  import psx_irq_pkg::*;

  localparam int N = IRQ_NUM_SRC;
`ifdef IRQ_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  addr = '0;
  logic [31:0]  data_i = '0;
  logic         wen = 1'b0;
  logic         ren = 1'b0;
  logic [3:0]   be = '0;
  logic         ack;
  logic [31:0]  data_o;
  logic [N-1:0] irq_src = '0;
  logic         cpu_irq;
  bus_state_t   dbg_state;

  always #5 clk = ~clk;

  irq_controller dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data_i    (data_i),
    .wen       (wen),
    .ren       (ren),
    .be        (be),
    .ack       (ack),
    .data_o    (data_o),
    .irq_src   (irq_src),
    .cpu_irq   (cpu_irq),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit is_hit(input logic [31:0] a);
    return (a[31:2] == I_STAT_ADDR[31:2]) || (a[31:2] == I_MASK_ADDR[31:2]);
  endfunction

  // ---------------- reference model ----------------
  // Registers as the programmer sees them. Each bus task call bumps req_seq;
  // the model applies that transaction once, on the first edge it sees it.
  // Sources are seen through a delay line as long as the synchronizer.
  int           req_seq  = 0;
  int           req_seen = 0;
  logic [N-1:0] m_stat = '0;
  logic [N-1:0] m_mask = '0;
  logic [N-1:0] m_prev = '0;
  logic         m_irq  = 1'b0;
  logic [N-1:0] dly_q[$];

  always @(posedge clk) begin
    logic [N-1:0] eff;
    logic [N-1:0] rise;
    logic [N-1:0] bm;
    if (rst) begin
      m_stat = '0;
      m_mask = '0;
      m_prev = irq_src;
      dly_q.delete();
      for (int i = 0; i < SYNC_STAGES; i++) dly_q.push_back(irq_src);
      req_seen = req_seq;
    end else begin
      dly_q.push_back(irq_src);
      eff    = dly_q.pop_front();
      rise   = eff & ~m_prev;
      m_prev = eff;
      if (req_seen != req_seq) begin
        req_seen = req_seq;
        for (int i = 0; i < N; i++) bm[i] = be[i/8];
        if (is_hit(addr)) begin
          if (ren) begin
            if (wen)                              exp_q.push_back(32'h0);
            else if (addr[31:2] == I_STAT_ADDR[31:2]) exp_q.push_back({{(32-N){1'b0}}, m_stat});
            else                                  exp_q.push_back({{(32-N){1'b0}}, m_mask});
          end
          if (wen) begin
            if (addr[31:2] == I_STAT_ADDR[31:2]) m_stat = m_stat & (data_i[N-1:0] | ~bm);
            else m_mask = (m_mask & ~bm) | (data_i[N-1:0] & bm);
          end
        end
      end
      m_stat = m_stat | rise;
    end
    m_irq = |(m_stat & m_mask);
  end

  // ---------------- driver tasks ----------------
  bit          chk_en = 1'b0;
  logic        ack_s;
  logic        irq_s;
  logic [31:0] data_s;

  // Sample outputs mid-cycle (negedge), then advance to just after the next edge
  task automatic step();
    @(negedge clk);
    ack_s  = ack;
    data_s = data_o;
    irq_s  = cpu_irq;
    if (chk_en) check("cpu_irq", {31'b0, cpu_irq}, {31'b0, m_irq});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
    step();
  endtask

  // Raise a request, hold it at least 'hold' cycles or until ack (bounded),
  // release it and watch a few more cycles for stray acks.
  task automatic bus_xfer(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b, input int hold,
                          output int acks, output logic [31:0] rd);
    wen = w; ren = r; addr = a; data_i = d; be = b;
    req_seq++;
    acks = 0;
    rd   = '0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (ack_s) begin
        acks++;
        rd = data_s;
        if (r) begin
          check("rd_queue_depth", exp_q.size(), 32'd1);
          if (exp_q.size() > 0) check("rdata", data_s, exp_q.pop_front());
        end
      end
      if (acks > 0 && c + 1 >= hold) break;
    end
    wen = 1'b0; ren = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (ack_s) acks++;
    end
    check("ack_count", acks, is_hit(a) ? 32'd1 : 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    int          acks;
    logic [31:0] rd;
    bus_xfer(1'b1, 1'b0, a, d, b, 1, acks, rd);
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] v);
    int acks;
    bus_xfer(1'b0, 1'b1, a, 32'h0, 4'h0, 1, acks, v);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [31:0] v;
    int          acks;
    int          lat;

    // Reset state
    do_reset(3);
    check("rst_ack", {31'b0, ack_s}, 32'd0);
    check("rst_data_o", data_s, 32'd0);
    check("rst_cpu_irq", {31'b0, irq_s}, 32'd0);
    chk_en = 1'b1;

    // One-cycle TMR0 pulse with mask clear: latched, no CPU interrupt
    irq_src[IRQ_TMR0] = 1'b1;
    step();
    irq_src[IRQ_TMR0] = 1'b0;
    repeat (4) step();
    rd_reg(I_STAT_ADDR, v);
    check("stat_tmr0", v, 32'h010);
    check("irq_masked", {31'b0, irq_s}, 32'd0);

    // Enable timer bits in the mask
    wr(I_MASK_ADDR, 32'h0000_0070, 4'b0011);
    check("irq_after_mask", {31'b0, irq_s}, 32'd1);
    rd_reg(I_MASK_ADDR, v);
    check("mask_070", v, 32'h070);

    // Acknowledge with the write held two cycles: single ack, stat cleared
    bus_xfer(1'b1, 1'b0, I_STAT_ADDR, 32'hFFFF_FFEF, 4'hF, 2, acks, v);
    check("held_wr_acks", acks, 32'd1);
    rd_reg(I_STAT_ADDR, v);
    check("stat_cleared", v, 32'h000);
    check("irq_after_clear", {31'b0, irq_s}, 32'd0);

    // Held VBLANK level cleared mid-pulse does not re-set until a new rise
    wr(I_MASK_ADDR, 32'h0000_0071, 4'hF);
    irq_src[IRQ_VBLANK] = 1'b1;
    repeat (10) step();
    wr(I_STAT_ADDR, 32'hFFFF_FFFE, 4'hF);
    repeat (20) step();
    rd_reg(I_STAT_ADDR, v);
    check("vblank_no_reset", v, 32'h000);
    check("vblank_irq_low", {31'b0, irq_s}, 32'd0);
    irq_src[IRQ_VBLANK] = 1'b0;
    repeat (3) step();
    irq_src[IRQ_VBLANK] = 1'b1;
    repeat (4) step();
    rd_reg(I_STAT_ADDR, v);
    check("vblank_new_rise", v, 32'h001);
    irq_src[IRQ_VBLANK] = 1'b0;
    wr(I_STAT_ADDR, 32'h0, 4'hF);

    // TMR1 rise arriving on the same edge as a clear of bit 5: set wins
    irq_src[IRQ_TMR1] = 1'b1;
    repeat (SYNC_STAGES) step();
    wr(I_STAT_ADDR, 32'hFFFF_FFDF, 4'hF);
    rd_reg(I_STAT_ADDR, v);
    check("set_wins", v, 32'h020);
    irq_src[IRQ_TMR1] = 1'b0;
    wr(I_STAT_ADDR, 32'h0, 4'hF);

    // Byte enables: only enabled bytes of the mask and stat change
    wr(I_MASK_ADDR, 32'hFFFF_FFFF, 4'b0001);
    rd_reg(I_MASK_ADDR, v);
    check("mask_be0", v, 32'h0FF);
    wr(I_MASK_ADDR, 32'hFFFF_FFFF, 4'b1110);
    rd_reg(I_MASK_ADDR, v);
    check("mask_be_hi", v, 32'h7FF);

    // Simultaneous wen and ren: write happens, read data is zero
    bus_xfer(1'b1, 1'b1, I_MASK_ADDR, 32'h0000_0155, 4'hF, 1, acks, v);
    check("wr_rd_data", v, 32'h0);
    rd_reg(I_MASK_ADDR, v);
    check("wr_rd_mask", v, 32'h155);

    // Unmapped addresses: no ack, no effect
    wr(32'h1F80_1078, 32'h0, 4'hF);
    rd_reg(32'h1F80_1000, v);
    rd_reg(I_MASK_ADDR + 32'd3, v);
    check("mask_after_miss", v, 32'h155);

    // TMR2 high through reset release: nothing latched
    irq_src = '0;
    irq_src[IRQ_TMR2] = 1'b1;
    do_reset(3);
    repeat (5) step();
    rd_reg(I_STAT_ADDR, v);
    check("tmr2_reset_release", v, 32'h000);
    wr(I_MASK_ADDR, 32'h0000_0040, 4'hF);
    irq_src[IRQ_TMR2] = 1'b0;
    repeat (4) step();
    // The first step samples the cycle before the capture edge
    irq_src[IRQ_TMR2] = 1'b1;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (irq_s) begin
        lat = c;
        break;
      end
    end
    check("irq_latency_steps", lat, 32'(SYNC_STAGES + 2));
    irq_src = '0;
    wr(I_STAT_ADDR, 32'h0, 4'hF);

    // Randomized traffic against the model
    for (int it = 0; it < 300; it++) begin
      int          sel;
      logic [31:0] a;
      irq_src = irq_src ^ (N'($urandom) & N'($urandom) & N'($urandom));
      sel = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0:       a = I_STAT_ADDR | 32'($urandom_range(0, 3));
        1:       a = I_MASK_ADDR | 32'($urandom_range(0, 3));
        2:       a = I_STAT_ADDR;
        default: a = (sel == 9) ? 32'h1F80_1078 : I_MASK_ADDR;
      endcase
      if (sel <= 3) begin
        repeat ($urandom_range(1, 3)) step();
      end else if (sel <= 5) begin
        rd_reg(a, v);
      end else if (sel <= 8) begin
        wr(a, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        bus_xfer(1'($urandom_range(0, 1)), 1'b1, a, $urandom, 4'hF,
                 $urandom_range(1, 4), acks, v);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
